// File: rtl/mcu_reset_seq.sv
// Reset sequencer for the MCU clock domain: staged power-on and system resets
// driven by PLL lock, core software/lockup reset handling and a sticky reset cause.
module mcu_reset_seq #(
  parameter int unsigned POR_DLY   = 16,
  parameter int unsigned SYS_DLY   = 8,
  parameter int unsigned SWRST_LEN = 32,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pll_locked_i,
  input  logic       sysresetreq_i,
  input  logic       lockup_i,
  input  logic       lockup_rst_en_i,
  input  logic       rst_cause_clr_i,
  output logic       porrstn_o,
  output logic       sysrstn_o,
  output logic [2:0] rst_cause_o
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    POR_HOLD,
    SYS_HOLD,
    RUN,
    SW_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_DLY - 1);
  localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_DLY - 1);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SWRST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_meta, lock_s;
  logic             por_d, sys_d;
  logic [2:0]       cause_d;
  logic             sw_req;
  logic             set_loss, set_sw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    por_d    = porrstn_o;
    sys_d    = sysrstn_o;
    set_loss = 1'b0;
    set_sw   = 1'b0;
    sw_req   = sysresetreq_i | (lockup_i & lockup_rst_en_i);

    case (state_q)
      WAIT_LOCK: begin
        por_d = 1'b0;
        sys_d = 1'b0;
        cnt_d = '0;
        if (lock_s) state_d = POR_HOLD;
      end
      POR_HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == POR_LAST) begin
          state_d = SYS_HOLD;
          cnt_d   = '0;
          por_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SYS_HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          por_d   = 1'b0;
          sys_d   = 1'b0;
        end else if (cnt_q == SYS_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          sys_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          por_d    = 1'b0;
          sys_d    = 1'b0;
          set_loss = 1'b1;
        end else if (sw_req) begin
          state_d = SW_HOLD;
          cnt_d   = '0;
          sys_d   = 1'b0;
          set_sw  = 1'b1;
        end
      end
      SW_HOLD: begin
        // Counter saturates so a held request can keep us here indefinitely.
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          por_d    = 1'b0;
          sys_d    = 1'b0;
          set_loss = 1'b1;
        end else if (cnt_q == SW_LAST && !sw_req) begin
          state_d = SYS_HOLD;
          cnt_d   = '0;
        end else if (cnt_q != SW_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        por_d   = 1'b0;
        sys_d   = 1'b0;
      end
    endcase

    // Set events win over a same-cycle clear for their own bit only.
    cause_d = (rst_cause_clr_i ? 3'b000 : rst_cause_o) | {set_sw, set_loss, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      porrstn_o   <= 1'b0;
      sysrstn_o   <= 1'b0;
      rst_cause_o <= 3'b001;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_meta   <= pll_locked_i;
      lock_s      <= lock_meta;
      porrstn_o   <= por_d;
      sysrstn_o   <= sys_d;
      rst_cause_o <= cause_d;
    end
  end

endmodule

// File: tb/tb_mcu_reset_seq.sv
// Bench for mcu_reset_seq: directed scenarios plus random traffic, checked each
// cycle against a timestamp-based reference model.
module tb_mcu_reset_seq;

  localparam int POR_DLY   = 16;
  localparam int SYS_DLY   = 8;
  localparam int SWRST_LEN = 32;
  localparam int CNT_W     = 8;

  logic       clk = 1'b0;
  logic       rstn, pll_locked_i, sysresetreq_i, lockup_i, lockup_rst_en_i, rst_cause_clr_i;
  logic       porrstn_o, sysrstn_o;
  logic [2:0] rst_cause_o;

  mcu_reset_seq #(
    .POR_DLY  (POR_DLY),
    .SYS_DLY  (SYS_DLY),
    .SWRST_LEN(SWRST_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .pll_locked_i   (pll_locked_i),
    .sysresetreq_i  (sysresetreq_i),
    .lockup_i       (lockup_i),
    .lockup_rst_en_i(lockup_rst_en_i),
    .rst_cause_clr_i(rst_cause_clr_i),
    .porrstn_o      (porrstn_o),
    .sysrstn_o      (sysrstn_o),
    .rst_cause_o    (rst_cause_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: release points are absolute edge numbers.
  bit       m_s1, m_ls, m_por, m_sys, m_seq, m_sw;
  int       t_por, t_sys, t_swmin;
  logic [2:0] m_cause = 3'b001;

  int  por_rise, por_fall, sys_rise, sys_fall;
  bit  prev_por, prev_sys;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at edge %0d: got %0b want %0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ls, req_ev, set_loss, set_sw, pu, su, sw;
    ls = m_ls;
    if (!rstn) begin
      m_s1 = 0; m_ls = 0; m_por = 0; m_sys = 0; m_seq = 0; m_sw = 0;
      m_cause = 3'b001;
      return;
    end
    m_ls = m_s1;
    m_s1 = pll_locked_i;
    req_ev   = sysresetreq_i | (lockup_i & lockup_rst_en_i);
    set_loss = 0;
    set_sw   = 0;
    pu = m_por; su = m_sys; sw = m_sw;
    if (!ls) begin
      set_loss = pu && (su || sw);
      m_por = 0; m_sys = 0; m_seq = 0; m_sw = 0;
    end else if (!m_seq) begin
      m_seq = 1;
      t_por = cyc + POR_DLY;
      t_sys = t_por + SYS_DLY;
    end else if (pu && su && req_ev) begin
      m_sys   = 0;
      m_sw    = 1;
      t_swmin = cyc + SWRST_LEN;
      set_sw  = 1;
    end else if (sw) begin
      if (cyc >= t_swmin && !req_ev) begin
        m_sw  = 0;
        t_sys = cyc + SYS_DLY;
      end
    end else begin
      if (cyc >= t_por) m_por = 1;
      if (pu && cyc >= t_sys) m_sys = 1;
    end
    m_cause = (rst_cause_clr_i ? 3'b000 : m_cause) | {set_sw, set_loss, 1'b0};
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("porrstn", {2'b00, porrstn_o}, {2'b00, m_por});
    chk("sysrstn", {2'b00, sysrstn_o}, {2'b00, m_sys});
    chk("cause", rst_cause_o, m_cause);
    if (porrstn_o === 1'b1 && !prev_por) por_rise = cyc;
    if (porrstn_o === 1'b0 &&  prev_por) por_fall = cyc;
    if (sysrstn_o === 1'b1 && !prev_sys) sys_rise = cyc;
    if (sysrstn_o === 1'b0 &&  prev_sys) sys_fall = cyc;
    prev_por = (porrstn_o === 1'b1);
    prev_sys = (sysrstn_o === 1'b1);
  endtask

  task automatic clr_trk();
    por_rise = -1; por_fall = -1; sys_rise = -1; sys_fall = -1;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) tick();
  endtask

  task automatic restart();
    rstn = 0; pll_locked_i = 0; sysresetreq_i = 0; lockup_i = 0;
    lockup_rst_en_i = 0; rst_cause_clr_i = 0;
    cyc = 0;
    repeat (5) tick();
    rstn = 1;
    clr_trk();
  endtask

  initial begin
    int drop_left, req_left, rst_left;

    // Cold start
    restart();
    chk("reset_por", {2'b00, porrstn_o}, 3'b000);
    chk("reset_sys", {2'b00, sysrstn_o}, 3'b000);
    chk("reset_cause", rst_cause_o, 3'b001);
    run_to(9);
    pll_locked_i = 1;
    run_to(40);
    chk_int("cold_por_rise", por_rise, 10 + POR_DLY + 2);
    chk_int("cold_sys_rise", sys_rise, 10 + POR_DLY + SYS_DLY + 2);
    chk("cold_cause", rst_cause_o, 3'b001);

    // Lock glitch during POR_HOLD
    restart();
    run_to(9);
    pll_locked_i = 1;
    run_to(19);
    pll_locked_i = 0;
    run_to(22);
    pll_locked_i = 1;
    run_to(50);
    chk_int("glitch_por_rise", por_rise, 23 + POR_DLY + 2);
    chk_int("glitch_sys_rise", sys_rise, 23 + POR_DLY + SYS_DLY + 2);

    // Lock loss in RUN and re-sequence
    run_to(99);
    pll_locked_i = 0;
    clr_trk();
    run_to(101);
    chk("loss_sys_still_up", {2'b00, sysrstn_o}, 3'b001);
    tick();
    chk("loss_por", {2'b00, porrstn_o}, 3'b000);
    chk("loss_sys", {2'b00, sysrstn_o}, 3'b000);
    chk("loss_cause", rst_cause_o, 3'b011);
    run_to(104);
    pll_locked_i = 1;
    run_to(140);
    chk_int("relock_por_rise", por_rise, 105 + POR_DLY + 2);
    chk_int("relock_sys_rise", sys_rise, 105 + POR_DLY + SYS_DLY + 2);

    // Software reset pulse
    clr_trk();
    run_to(199);
    sysresetreq_i = 1;
    tick();
    sysresetreq_i = 0;
    run_to(245);
    chk_int("sw_sys_fall", sys_fall, 200);
    chk_int("sw_sys_rise", sys_rise, 200 + SWRST_LEN + SYS_DLY);
    chk_int("sw_por_steady", por_fall, -1);
    chk("sw_cause", rst_cause_o, 3'b111);

    // Held request
    clr_trk();
    run_to(259);
    sysresetreq_i = 1;
    repeat (50) tick();
    sysresetreq_i = 0;
    run_to(330);
    chk_int("held_sys_fall", sys_fall, 260);
    chk_int("held_low_len", sys_rise - sys_fall, 50 + SYS_DLY);

    // Lockup without enable must not reset
    clr_trk();
    lockup_i = 1;
    lockup_rst_en_i = 0;
    repeat (20) tick();
    lockup_i = 0;
    chk_int("lockup_gated", sys_fall, -1);
    chk("lockup_gated_sys", {2'b00, sysrstn_o}, 3'b001);

    // Cause clear colliding with a software reset event
    restart();
    run_to(9);
    pll_locked_i = 1;
    run_to(49);
    pll_locked_i = 0;
    run_to(54);
    pll_locked_i = 1;
    run_to(90);
    chk("coll_pre_cause", rst_cause_o, 3'b011);
    sysresetreq_i = 1;
    rst_cause_clr_i = 1;
    tick();
    sysresetreq_i = 0;
    rst_cause_clr_i = 0;
    chk("coll_cause", rst_cause_o, 3'b100);
    run_to(140);

    // Random traffic against the model
    drop_left = 0; req_left = 0; rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rst_left > 0) begin
        rst_left--;
        rstn = (rst_left == 0);
      end else if ($urandom_range(0, 999) == 0) begin
        rst_left = $urandom_range(1, 3);
        rstn = 0;
      end
      if (drop_left > 0) drop_left--;
      else if ($urandom_range(0, 299) == 0) drop_left = $urandom_range(1, 4);
      pll_locked_i = (drop_left == 0);
      if (req_left > 0) req_left--;
      else if ($urandom_range(0, 79) == 0) req_left = $urandom_range(1, 45);
      sysresetreq_i = (req_left != 0);
      if ($urandom_range(0, 49) == 0) lockup_i = ~lockup_i;
      if ($urandom_range(0, 99) == 0) lockup_rst_en_i = ~lockup_rst_en_i;
      rst_cause_clr_i = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
